// File: rtl/cpu_pkg.sv
// Shared RV32I-subset encodings, ALU operations and the decoded-control bundle.
// Types and constants only; no timing or flow-control behaviour.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    src_imm;
    logic    mem_write;
    logic    branch;
    logic    branch_ne;
    logic    jal;
    wb_sel_t wb_sel;
  } ctrl_t;

endpackage

// File: rtl/cpu_alu.sv
// 32-bit integer ALU; wraps modulo 2^32, shifts use b[4:0].
// Latency: combinational; backpressure: none.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   result = {31'd0, a < b};
      ALU_SLL:    result = a << b[4:0];
      ALU_SRL:    result = a >> b[4:0];
      ALU_SRA:    result = $signed(a) >>> b[4:0];
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Decoder: control bundle, sign-extended immediate and rd write enable.
// Latency: combinational; backpressure: none.
module cpu_control
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        regWrite,
  output logic [31:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       writes_rd;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  always_comb begin
    ctrl = '{alu_op: ALU_ADD, src_imm: 1'b0, mem_write: 1'b0, branch: 1'b0,
             branch_ne: 1'b0, jal: 1'b0, wb_sel: WB_ALU};
    imm       = {{20{instr[31]}}, instr[31:20]};
    writes_rd = 1'b0;
    case (opcode)
      OP_R: begin
        writes_rd = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}:  ctrl.alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD}:  ctrl.alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}:  ctrl.alu_op = ALU_SLL;
          {F7_BASE, F3_SLT}:  ctrl.alu_op = ALU_SLT;
          {F7_BASE, F3_SLTU}: ctrl.alu_op = ALU_SLTU;
          {F7_BASE, F3_XOR}:  ctrl.alu_op = ALU_XOR;
          {F7_BASE, F3_SR}:   ctrl.alu_op = ALU_SRL;
          {F7_ALT,  F3_SR}:   ctrl.alu_op = ALU_SRA;
          {F7_BASE, F3_OR}:   ctrl.alu_op = ALU_OR;
          {F7_BASE, F3_AND}:  ctrl.alu_op = ALU_AND;
          default:            writes_rd = 1'b0;
        endcase
      end
      OP_I: begin
        ctrl.src_imm = 1'b1;
        writes_rd    = 1'b1;
        case (funct3)
          F3_ADD:  ctrl.alu_op = ALU_ADD;
          F3_AND:  ctrl.alu_op = ALU_AND;
          F3_OR:   ctrl.alu_op = ALU_OR;
          F3_XOR:  ctrl.alu_op = ALU_XOR;
          F3_SLT:  ctrl.alu_op = ALU_SLT;
          default: writes_rd = 1'b0;
        endcase
      end
      OP_LOAD: if (funct3 == F3_LW) begin
        ctrl.src_imm = 1'b1;
        ctrl.wb_sel  = WB_MEM;
        writes_rd    = 1'b1;
      end
      OP_STORE: if (funct3 == F3_SW) begin
        ctrl.src_imm   = 1'b1;
        ctrl.mem_write = 1'b1;
        imm            = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = (funct3 == F3_BNE);
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_JAL: begin
        ctrl.jal    = 1'b1;
        ctrl.wb_sel = WB_PC4;
        writes_rd   = 1'b1;
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_LUI: begin
        ctrl.alu_op  = ALU_PASS_B;
        ctrl.src_imm = 1'b1;
        writes_rd    = 1'b1;
        imm          = {instr[31:12], 12'h000};
      end
      default: ;
    endcase
  end

  // A write aimed at x0 is not a register write, so the probe stays low for it.
  assign regWrite = writes_rd && (rd != 5'd0);

endmodule

// File: rtl/cpu_dmem.sv
// Word-addressed data RAM, contents survive reset.
// Latency: combinational read, write on the edge; backpressure: none.
module cpu_dmem #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]   mem [DMEM_WORDS];
  logic [AW-1:0] idx;
  logic          unused_addr_bits;

  assign idx              = addr[AW+1:2];
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/cpu_imem.sv
// Instruction ROM holding the Fibonacci program; unmapped words read as NOP.
// Latency: combinational fetch; backpressure: none.
module cpu_imem
  import cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 64
) (
  input  logic [31:0] addr,
  output logic [31:0] instr
);

  logic [31:0] word_idx;
  logic        unused_byte_sel;

  assign word_idx        = {2'b00, addr[31:2]};
  assign unused_byte_sel = ^addr[1:0];

  always_comb begin
    instr = NOP_INSTR;
    if (word_idx < $unsigned(IMEM_WORDS)) begin
      case (word_idx)
        32'd0:   instr = 32'h0000_0093;
        32'd1:   instr = 32'h0010_0113;
        32'd2:   instr = 32'h0050_0213;
        32'd3:   instr = 32'h0020_81B3;
        32'd4:   instr = 32'h0001_0093;
        32'd5:   instr = 32'h0001_8113;
        32'd6:   instr = 32'hFFF2_0213;
        32'd7:   instr = 32'hFE02_18E3;
        32'd8:   instr = 32'h0000_006F;
        default: instr = NOP_INSTR;
      endcase
    end
  end

endmodule

// File: rtl/cpu_pc.sv
// Program counter register; async active-low reset to RESET_PC.
// Latency: next PC visible one edge later; backpressure: none, advances every edge.
module cpu_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  output logic [31:0] pc_out
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_out <= RESET_PC;
    else      pc_out <= pc_next;
  end

endmodule

// File: rtl/cpu_regfile.sv
// 32x32 register file, two combinational reads, one write; x0 hardwired to zero.
// Latency: write lands on the edge, same-cycle read sees old value; backpressure: none.
module cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I-subset core running the ROM program.
// Latency: one instruction retires per rising edge; backpressure: none.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst
);

  logic [31:0] pc, pc_next, instr, imm;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_res, mem_rdata, wb_data;
  ctrl_t       ctrl;
  logic        reg_write, take_branch;

  cpu_pc #(.RESET_PC(RESET_PC)) pc_inst (
    .clk(clk), .rst(rst), .pc_next(pc_next), .pc_out(pc)
  );

  cpu_imem #(.IMEM_WORDS(IMEM_WORDS)) imem (.addr(pc), .instr(instr));

  cpu_control control_inst (
    .instr(instr), .ctrl(ctrl), .regWrite(reg_write), .imm(imm)
  );

  cpu_regfile rf_inst (
    .clk(clk), .rst(rst), .ra1(instr[19:15]), .ra2(instr[24:20]),
    .wa(instr[11:7]), .we(reg_write), .wd(wb_data), .rd1(rs1_val), .rd2(rs2_val)
  );

  assign alu_b = ctrl.src_imm ? imm : rs2_val;

  cpu_alu alu_inst (.a(rs1_val), .b(alu_b), .op(ctrl.alu_op), .result(alu_res));

  // Gating with rst keeps a store from landing while the core is held in reset.
  cpu_dmem #(.DMEM_WORDS(DMEM_WORDS)) dmem_inst (
    .clk(clk), .we(ctrl.mem_write & rst), .addr(alu_res), .wd(rs2_val), .rdata(mem_rdata)
  );

  always_comb begin
    case (ctrl.wb_sel)
      WB_MEM:  wb_data = mem_rdata;
      WB_PC4:  wb_data = pc + 32'd4;
      default: wb_data = alu_res;
    endcase
  end

  assign take_branch = ctrl.branch && ((alu_res == 32'd0) ^ ctrl.branch_ne);
  assign pc_next     = (ctrl.jal || take_branch) ? pc + imm : pc + 32'd4;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench: reset, Fibonacci run, halt loop, mid-loop async reset, ALU vectors.
module tb_cpu_core;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  int          total;
  int          bad;
  logic [31:0] ut_a, ut_b, ut_res;
  alu_op_t     ut_op;
  logic [31:0] p_pc, p_instr, p_alu;
  logic        p_rw;

  cpu_core dut (.clk(clk), .rst(rst));
  cpu_alu  ut_alu (.a(ut_a), .b(ut_b), .op(ut_op), .result(ut_res));

  assign p_pc    = dut.pc_inst.pc_out;
  assign p_instr = dut.imem.instr;
  assign p_alu   = dut.alu_inst.result;
  assign p_rw    = dut.control_inst.regWrite;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] e3, input logic [31:0] e4);
    check({tag, "_x1"}, dut.rf_inst.regs[1], e1);
    check({tag, "_x2"}, dut.rf_inst.regs[2], e2);
    check({tag, "_x3"}, dut.rf_inst.regs[3], e3);
    check({tag, "_x4"}, dut.rf_inst.regs[4], e4);
  endtask

  task automatic check_all_zero(input string tag);
    int nz = 0;
    for (int i = 1; i < 32; i++) if (dut.rf_inst.regs[i] != 32'd0) nz++;
    check(tag, nz, 0);
  endtask

  // Starts just before the first edge after reset release; leaves the core at 0x20.
  task automatic run_fib(input string tag);
    logic [31:0] seq_pc  [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] seq_alu [3] = '{32'd0, 32'd1, 32'd5};
    logic [31:0] add_exp [5] = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd8};
    logic [31:0] bne_exp [5] = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    int n_add = 0;
    for (int e = 0; e < 28; e++) begin
      if (e < 3) begin
        check({tag, "_seq_pc"}, p_pc, seq_pc[e]);
        check({tag, "_seq_alu"}, p_alu, seq_alu[e]);
        check({tag, "_seq_rw"}, {31'd0, p_rw}, 32'd1);
      end
      if (p_pc == 32'h0C && n_add < 5) begin
        check({tag, "_add"}, p_alu, add_exp[n_add]);
        check({tag, "_add_rw"}, {31'd0, p_rw}, 32'd1);
        n_add++;
      end
      if (p_pc == 32'h1C && n_add >= 1) begin
        check({tag, "_bne_rw"}, {31'd0, p_rw}, 32'd0);
        check({tag, "_bne_alu"}, p_alu, bne_exp[n_add-1]);
        check({tag, "_bne_instr"}, p_instr, 32'hFE02_18E3);
      end
      @(negedge clk);
    end
    check({tag, "_n_add"}, n_add, 5);
    check({tag, "_end_pc"}, p_pc, 32'h20);
    check_regs({tag, "_end"}, 32'd5, 32'd8, 32'd8, 32'd0);
  endtask

  task automatic alu_vec(input string tag, input alu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    ut_op = op;
    ut_a  = a;
    ut_b  = b;
    #1;
    check(tag, ut_res, exp);
  endtask

  initial begin
    int found;
    total = 0;
    bad   = 0;
    ut_op = ALU_ADD;
    ut_a  = '0;
    ut_b  = '0;
    rst   = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_pc", p_pc, 32'h0);
    check("rst_instr", p_instr, 32'h0000_0093);
    check_all_zero("rst_regs");
    rst = 1'b1;

    run_fib("run1");

    for (int i = 0; i < 10; i++) begin
      check("halt_pc", p_pc, 32'h20);
      check("halt_rw", {31'd0, p_rw}, 32'd0);
      @(negedge clk);
    end
    check("halt_pc_end", p_pc, 32'h20);
    check_regs("halt", 32'd5, 32'd8, 32'd8, 32'd0);

    // Restart, then fire reset between edges once PC reaches 0x14.
    #2 rst = 1'b0;
    #1;
    check("restart_pc", p_pc, 32'h0);
    rst = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (p_pc == 32'h14) found = 1;
    end
    check("reach_0x14", found, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_pc", p_pc, 32'h0);
    check_all_zero("async_rst_regs");
    #1 rst = 1'b1;

    run_fib("run2");

    alu_vec("alu_add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec("alu_sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
    alu_vec("alu_slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec("alu_sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec("alu_sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_vec("alu_srl", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_vec("alu_sll_b40", ALU_SLL, 32'd1, 32'd33, 32'd2);
    alu_vec("alu_xor", ALU_XOR, 32'hF0F0_1234, 32'h0FF0_1030, 32'hFF00_0204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Single-cycle RV32I-subset processor core. Instruction ROM preloaded with a Fibonacci program.
- Top-level block with no data ports, only clock and reset.
- Observed by hierarchical probes of PC, instruction, ALU result and register-write enable.
- One instruction retires per rising clock edge.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words.
- DMEM_WORDS, 64, data RAM depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Name kept as "rst"; polarity is active-low despite the name.

Behaviour:
Reset:
- rst=0 asynchronously forces PC=RESET_PC and clears x1..x31 to 0.
- Data RAM is not cleared.
- Deassertion is sampled at the next rising edge.
- rst asserted mid-program aborts the current instruction (no writeback) and restarts at 0x0.

Datapath:
- Instruction fetch is combinational from ROM word PC[31:2]. PC[1:0] are ignored.
- Addresses beyond IMEM_WORDS return 32'h0000_0013 (NOP).
- Register file: 32x32.
  - x0 reads 0; writes to x0 are discarded.
  - Two combinational read ports, one synchronous write port.
  - Write-then-read in the same cycle returns the old value.

Supported instructions:
- R-type: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
- I-type ALU: ADDI, ANDI, ORI, XORI, SLTI.
- LW, SW, BEQ, BNE, JAL, LUI.
- Any other opcode is a NOP: no register write, no memory write, PC+4.

Arithmetic and memory rules:
- Arithmetic is 32-bit, wraps modulo 2^32, and raises no overflow flag.
- Shifts use rs2[4:0] / imm[4:0].
- Immediates are sign-extended per the RV32I formats.
- Data RAM: combinational read, write on the rising edge when SW is executed. Address word = ALU result[31:2].

Next PC:
- Branch taken: PC+Bimm. JAL: PC+Jimm, with rd written PC+4. Otherwise PC+4.

Required probe points:
- Instance pc_inst, output pc_out = current PC.
- Instance imem, output instr = fetched word.
- Instance alu_inst, output result.
- Instance control_inst, output regWrite = 1 exactly when the current instruction writes rd.

ROM contents (word address: encoding, meaning); all other words are NOP:
- 0x00: 00000093  addi x1,x0,0
- 0x04: 00100113  addi x2,x0,1
- 0x08: 00500213  addi x4,x0,5
- 0x0C: 002081B3  add x3,x1,x2
- 0x10: 00010093  addi x1,x2,0
- 0x14: 00018113  addi x2,x3,0
- 0x18: FFF20213  addi x4,x4,-1
- 0x1C: FE0218E3  bne x4,x0,-16
- 0x20: 0000006F  jal x0,0 (halt loop)

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI);
  - funct3/funct7 constants;
  - enum alu_op_t;
  - NOP encoding.
- Sub-modules:
  - cpu_pc (pc_inst)
  - cpu_imem (imem)
  - cpu_control (control_inst)
  - cpu_alu (alu_inst)
  - cpu_regfile
  - cpu_dmem
- cpu_alu is the natural standalone unit and is tested separately.

Test Plan:
- Reset: hold rst=0 for 2 ns, release at t=2 ns with a 10 ns clock -> pc_out=0x0 and instr=0x00000093 while reset is held; x1..x31=0.
- Sequencing: first three edges after release -> PC steps 0x0, 0x4, 0x8, 0xC; regWrite=1 on each; alu_out=0, 1, 5.
- Fibonacci: after 28 edges -> PC=0x20, x1=5, x2=8, x3=8, x4=0. Within the loop, the successive add results at PC 0x0C are 1, 2, 3, 5, 8. BNE has regWrite=0 and alu_out = x4 - 0.
- Halt: 10 further edges -> PC stays 0x20, registers unchanged, regWrite=0.
- Async reset mid-loop: assert rst=0 between edges while PC=0x14 -> PC is 0x0 immediately without waiting for a clock. After release, the program reruns to the same final values.
- ALU unit: ADD 0xFFFFFFFF+1 -> 0. SUB 0-1 -> 0xFFFFFFFF. SLT -1<1 -> 1. SLTU -> 0. SRA 0x80000000>>4 -> 0xF8000000.
